// File: rtl/disp_sched.sv
// disp_sched - display scheduler for the four HEX digits of the
// temperature-monitor board.
//
// Decides what the four seven_seg digits show: the BCD entry editor,
// the current-temperature page, the difference (subtractor) page, or a
// flashing alarm overlay.  It also owns the display tick prescaler, the
// page dwell timer and the blink phase.
//
// Parameters
//   DIV          clk cycles per display tick (>= 2)
//   DWELL        ticks spent on TEMP or DIFF before alternating
//   ALARM_TICKS  ticks the ALARM page is held after an alarm edge
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   entry_active  BCD entry in progress (highest priority)
//   entry_digit   digit being edited, 0=ones..2=huns, 3 behaves as 2
//   entry_val     entered BCD {huns, tens, ones}
//   entry_sign    entry sign switch
//   temp_val      current temperature BCD
//   diff_val      subtractor result BCD
//   diff_neg      subtractor negative flag
//   alarm_req     alarm request level (rising edge detected here)
//   hex0..hex3    registered digit codes (0-9, `OFF, `NEGATIVE)
//   digit_en      registered per-digit enable, bit n drives HEXn
//   page          current page / FSM state: 0=ENTRY 1=TEMP 2=DIFF 3=ALARM
//   tick          one-cycle pulse while the prescaler sits at DIV-1
//   blink         blink phase, toggles at the start of every tick
//
// Build option
//   LEADING_ZERO_BLANK_EN  blank leading zero hundreds/tens digits on the
//                          TEMP, DIFF and ALARM pages (ENTRY unaffected).
//
// Handshake: none; all inputs are levels sampled every clock and all
// outputs are registered with one clock of latency.

`ifndef OFF
`define OFF 4'hF
`endif
`ifndef NEGATIVE
`define NEGATIVE 4'hE
`endif

module disp_sched #(
  parameter int DIV         = 12500000,
  parameter int DWELL       = 8,
  parameter int ALARM_TICKS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_active,
  input  logic [1:0]  entry_digit,
  input  logic [11:0] entry_val,
  input  logic        entry_sign,
  input  logic [11:0] temp_val,
  input  logic [11:0] diff_val,
  input  logic        diff_neg,
  input  logic        alarm_req,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic [3:0]  digit_en,
  output logic [1:0]  page,
  output logic        tick,
  output logic        blink
);

  localparam int CW = $clog2(DIV);
  localparam int DW = $clog2(DWELL + 2);
  localparam int AW = $clog2(ALARM_TICKS + 2);

  typedef enum logic [1:0] {
    PG_ENTRY = 2'd0,
    PG_TEMP  = 2'd1,
    PG_DIFF  = 2'd2,
    PG_ALARM = 2'd3
  } page_t;

  // ---------------------------------------------------------------
  // Prescaler.  tick and blink are registered one count early so that
  // tick is high exactly while the count equals DIV-1 and blink flips
  // at the start of that same cycle.
  // ---------------------------------------------------------------
  logic [CW-1:0] pre_cnt;
  logic          pre_last;
  logic          pre_almost;

  assign pre_last   = (pre_cnt == CW'(DIV - 1));
  assign pre_almost = (pre_cnt == CW'(DIV - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      blink   <= 1'b0;
    end else begin
      pre_cnt <= pre_last ? '0 : pre_cnt + CW'(1);
      tick    <= pre_almost;
      if (pre_almost) blink <= ~blink;
    end
  end

  // ---------------------------------------------------------------
  // Page FSM
  // ---------------------------------------------------------------
  page_t         page_q, page_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          alarm_q;
  logic          alarm_edge;

  // The edge register tracks alarm_req unconditionally, so an edge that
  // arrives while entry is active is consumed and never replayed.
  assign alarm_edge = alarm_req & ~alarm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page_q  <= PG_TEMP;
      dwell_q <= '0;
      acnt_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      page_q  <= page_d;
      dwell_q <= dwell_d;
      acnt_q  <= acnt_d;
      alarm_q <= alarm_req;
    end
  end

  always_comb begin
    page_d  = page_q;
    dwell_d = dwell_q;
    acnt_d  = acnt_q;
    if (entry_active) begin
      page_d = PG_ENTRY;
      acnt_d = '0;
    end else if (alarm_edge) begin
      // Also covers a re-trigger while already in ALARM (reload).
      page_d = PG_ALARM;
      acnt_d = AW'(ALARM_TICKS);
    end else begin
      case (page_q)
        PG_ENTRY: begin
          page_d  = PG_TEMP;
          dwell_d = '0;
        end
        PG_TEMP, PG_DIFF: begin
          if (tick) begin
            if (dwell_q == DW'(DWELL - 1)) begin
              page_d  = (page_q == PG_TEMP) ? PG_DIFF : PG_TEMP;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
        end
        default: begin
          // ALARM: leave on the tick that would take the counter to 0.
          if (tick) begin
            if (acnt_q <= AW'(1)) begin
              page_d  = PG_TEMP;
              dwell_d = '0;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q - AW'(1);
            end
          end
        end
      endcase
    end
  end

  assign page = page_q;

  // ---------------------------------------------------------------
  // Digit mapping (registered below)
  // ---------------------------------------------------------------
  logic [1:0]  sel_digit;
  logic [11:0] src;
  logic [15:0] hex_d;
  logic [3:0]  en_d;

  assign sel_digit = (entry_digit == 2'd3) ? 2'd2 : entry_digit;

  always_comb begin
    hex_d = {4{`OFF}};
    en_d  = 4'b1111;
    src   = (page_q == PG_DIFF) ? diff_val : temp_val;
    if (page_q == PG_ENTRY) begin
      // Digits above the edited one stay `OFF with enable 1.
      for (int i = 0; i < 3; i++) begin
        if (i <= int'(sel_digit)) hex_d[4*i +: 4] = entry_val[4*i +: 4];
        if (i == int'(sel_digit)) en_d[i] = blink;
      end
      hex_d[15:12] = entry_sign ? `NEGATIVE : `OFF;
    end else begin
      hex_d[11:0] = src;
      if (page_q == PG_DIFF && diff_neg) hex_d[15:12] = `NEGATIVE;
      if (page_q == PG_ALARM) en_d = {4{blink}};
`ifdef LEADING_ZERO_BLANK_EN
      if (src[11:8] == 4'd0) begin
        hex_d[11:8] = `OFF;
        if (src[7:4] == 4'd0) hex_d[7:4] = `OFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hex0     <= `OFF;
      hex1     <= `OFF;
      hex2     <= `OFF;
      hex3     <= `OFF;
      digit_en <= 4'b0000;
    end else begin
      hex0     <= hex_d[3:0];
      hex1     <= hex_d[7:4];
      hex2     <= hex_d[11:8];
      hex3     <= hex_d[15:12];
      digit_en <= en_d;
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched - self-checking bench for disp_sched (DIV=4, DWELL=2,
// ALARM_TICKS=3).  A reference model driven from the absolute cycle
// count since reset release predicts page, digits, enables, tick and
// blink; expectations go into exp_q when a cycle is driven and are
// popped and compared one clock later.
module tb_disp_sched;

  localparam int DIV         = 4;
  localparam int DWELL       = 2;
  localparam int ALARM_TICKS = 3;

  localparam int P_ENTRY = 0;
  localparam int P_TEMP  = 1;
  localparam int P_DIFF  = 2;
  localparam int P_ALARM = 3;

`ifdef OFF
  localparam logic [3:0] C_OFF = `OFF;
`else
  localparam logic [3:0] C_OFF = 4'hF;
`endif
`ifdef NEGATIVE
  localparam logic [3:0] C_NEG = `NEGATIVE;
`else
  localparam logic [3:0] C_NEG = 4'hE;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        entry_active;
  logic [1:0]  entry_digit;
  logic [11:0] entry_val;
  logic        entry_sign;
  logic [11:0] temp_val;
  logic [11:0] diff_val;
  logic        diff_neg;
  logic        alarm_req;
  logic [3:0]  hex0, hex1, hex2, hex3, digit_en;
  logic [1:0]  page;
  logic        tick, blink;

  always #5 clk = ~clk;

  disp_sched #(.DIV(DIV), .DWELL(DWELL), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .rst(rst),
    .entry_active(entry_active), .entry_digit(entry_digit),
    .entry_val(entry_val), .entry_sign(entry_sign),
    .temp_val(temp_val), .diff_val(diff_val), .diff_neg(diff_neg),
    .alarm_req(alarm_req),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .digit_en(digit_en), .page(page), .tick(tick), .blink(blink)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];   // {page, hex3, hex2, hex1, hex0, en, tick, blink}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   k;          // clock edges since reset release
  int   m_page;
  logic m_blink;
  int   switch_at;  // edge at which TEMP/DIFF next alternates
  int   alarm_end;  // edge at which ALARM returns to TEMP
  logic m_aprev;

  // Edge index of the n-th tick-consuming edge strictly after edge e.
  function automatic int nth_tick_after(int e, int n);
    return (e / DIV + n) * DIV;
  endfunction

  task automatic model_reset();
    k         = 0;
    m_page    = P_TEMP;
    m_blink   = 1'b0;
    switch_at = nth_tick_after(0, DWELL);
    alarm_end = 0;
    m_aprev   = 1'b0;
  endtask

  function automatic logic [19:0] disp(int pg, logic b);
    logic [3:0]  h[4];
    logic [3:0]  en;
    logic [11:0] v;
    int          sd;
    for (int i = 0; i < 4; i++) h[i] = C_OFF;
    en = 4'b1111;
    if (pg == P_ENTRY) begin
      sd = (entry_digit == 2'd3) ? 2 : int'(entry_digit);
      v  = entry_val;
      for (int i = 0; i < 3; i++) begin
        if (i <= sd) h[i] = v[4*i +: 4];
        if (i == sd) en[i] = b;
      end
      h[3] = entry_sign ? C_NEG : C_OFF;
    end else begin
      v = (pg == P_DIFF) ? diff_val : temp_val;
      h[0] = v[3:0];
      h[1] = v[7:4];
      h[2] = v[11:8];
      if (pg == P_DIFF && diff_neg) h[3] = C_NEG;
      if (pg == P_ALARM) en = {4{b}};
`ifdef LEADING_ZERO_BLANK_EN
      if (v[11:8] == 4'd0) begin
        h[2] = C_OFF;
        if (v[7:4] == 4'd0) h[1] = C_OFF;
      end
`endif
    end
    return {h[3], h[2], h[1], h[0], en};
  endfunction

  // Drive one cycle: called at a negedge with inputs already set.
  task automatic step();
    logic [19:0] d;
    logic [23:0] x;
    int          e;
    int          np;
    logic        exp_tick;
    logic        exp_blink;
    d  = disp(m_page, m_blink);
    e  = k + 1;
    np = m_page;
    if (entry_active) begin
      np = P_ENTRY;
    end else if (alarm_req && !m_aprev) begin
      np        = P_ALARM;
      alarm_end = nth_tick_after(e, ALARM_TICKS);
    end else if (m_page == P_ENTRY) begin
      np        = P_TEMP;
      switch_at = nth_tick_after(e, DWELL);
    end else if (m_page == P_ALARM) begin
      if (e == alarm_end) begin
        np        = P_TEMP;
        switch_at = nth_tick_after(e, DWELL);
      end
    end else if (e == switch_at) begin
      np        = (m_page == P_TEMP) ? P_DIFF : P_TEMP;
      switch_at = nth_tick_after(e, DWELL);
    end
    m_aprev   = alarm_req;
    exp_tick  = ((e % DIV) == DIV - 1);
    exp_blink = (((e + 1) / DIV) % 2) == 1;
    exp_q.push_back({2'(np), d, exp_tick, exp_blink});
    m_page  = np;
    m_blink = exp_blink;
    k       = e;

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check("page",     page,     x[23:22]);
      check("hex3",     hex3,     x[21:18]);
      check("hex2",     hex2,     x[17:14]);
      check("hex1",     hex1,     x[13:10]);
      check("hex0",     hex0,     x[9:6]);
      check("digit_en", digit_en, x[5:2]);
      check("tick",     tick,     x[1]);
      check("blink",    blink,    x[0]);
    end
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(int p, int budget);
    int n;
    n = 0;
    while (m_page != p && n < budget) begin
      step();
      n++;
    end
    check("reach_page", page, p);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_page"},  page,     P_TEMP);
    check({tag, "_hex0"},  hex0,     C_OFF);
    check({tag, "_hex1"},  hex1,     C_OFF);
    check({tag, "_hex2"},  hex2,     C_OFF);
    check({tag, "_hex3"},  hex3,     C_OFF);
    check({tag, "_en"},    digit_en, 4'b0000);
    check({tag, "_tick"},  tick,     1'b0);
    check({tag, "_blink"}, blink,    1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    entry_active = 1'b0;
    entry_digit  = 2'd0;
    entry_val    = 12'h000;
    entry_sign   = 1'b0;
    temp_val     = 12'h025;
    diff_val     = 12'h013;
    diff_neg     = 1'b1;
    alarm_req    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b1;
    model_reset();

    // Idle: TEMP, DIFF, TEMP with switches every DWELL*DIV clocks.
    run(24);

    // Entry editing tens digit with negative sign, then release.
    entry_active = 1'b1;
    entry_digit  = 2'd1;
    entry_val    = 12'h047;
    entry_sign   = 1'b1;
    run(12);
    entry_active = 1'b0;
    run(3);

    // Alarm from DIFF, then a re-trigger while ALARM is running.
    run_until(P_DIFF, 40);
    alarm_req = 1'b1;
    run(6);
    alarm_req = 1'b0;
    run(1);
    alarm_req = 1'b1;
    run(20);

    // Alarm edge coincident with entry: discarded.
    alarm_req = 1'b0;
    run(2);
    entry_active = 1'b1;
    alarm_req    = 1'b1;
    run(5);
    entry_active = 1'b0;
    run(20);
    alarm_req = 1'b0;

    // Leading-zero value and digit index 3 (behaves as 2).
    temp_val = 12'h005;
    run(6);
    entry_active = 1'b1;
    entry_digit  = 2'd3;
    entry_val    = 12'h005;
    entry_sign   = 1'b0;
    run(6);
    entry_digit = 2'd0;
    run(5);
    entry_active = 1'b0;
    run(4);

    // Randomised mix, including nibbles above 9.
    for (int it = 0; it < 12; it++) begin
      temp_val   = 12'($urandom_range(0, 4095));
      diff_val   = 12'($urandom_range(0, 4095));
      diff_neg   = 1'($urandom_range(0, 1));
      entry_val  = 12'($urandom_range(0, 4095));
      entry_digit = 2'($urandom_range(0, 3));
      entry_sign = 1'($urandom_range(0, 1));
      entry_active = 1'($urandom_range(0, 1));
      alarm_req  = 1'($urandom_range(0, 1));
      run($urandom_range(2, 12));
    end
    entry_active = 1'b0;
    alarm_req    = 1'b0;
    run(10);

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    model_reset();
    temp_val = 12'h025;
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
